imem_loader: RTL and testbench

- Upstream feeder of the instruction memory. Receives a framed byte stream from the host link (UART RX byte strobe) and assembles little-endian 32-bit instruction words.
- Drives the instruction memory write port (wr_en/wr_addr/wr_data).
- Holds the core in reset via cpu_hold until a complete, checksum-valid program image has been written.

---
 rtl/imem_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream from the host link and writes the
// program image into instruction memory. It holds the core in reset until a
// complete, checksum-valid image has been loaded.
//
// Frame: 0xA5 | CNT_LO | CNT_HI | N words x 4 bytes (little-endian) | CSUM
//        CSUM is the XOR of all 4N payload bytes.
//
// Ports:
//   clk, reset  clock; asynchronous active-high reset
//   rx_valid    one-cycle strobe, rx_data holds a new byte
//   rx_data     received byte
//   wr_en       instruction memory write strobe, one cycle per word
//   wr_addr     byte address of the word being written
//   wr_data     word being written, byte0 in [7:0]
//   cpu_hold    high keeps the core in reset
//   busy        frame in progress
//   load_done   last frame loaded successfully (sticky)
//   load_err    last frame failed (sticky)
module imem_loader #(
   parameter int unsigned PC_WIDTH       = 32,
   parameter int unsigned INST_WIDTH     = 32,
   parameter int unsigned IMEM_BYTES     = 4096,
   parameter int unsigned BASE_ADDR      = 0,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  wr_en,
   output logic [PC_WIDTH-1:0]   wr_addr,
   output logic [INST_WIDTH-1:0] wr_data,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CNT_LO = 3'd1;
   localparam logic [2:0] S_CNT_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CSUM   = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   localparam logic [7:0]          SYNC_BYTE = 8'hA5;
   localparam logic [PC_WIDTH-1:0] BASE      = PC_WIDTH'(BASE_ADDR);

   logic [2:0]            state_q, state_d;
   logic [7:0]            cnt_lo_q, cnt_lo_d;
   logic [15:0]           nwords_q, nwords_d;
   logic [15:0]           wcnt_q, wcnt_d;
   logic [1:0]            lane_q, lane_d;
   logic [23:0]           asm_q, asm_d;
   logic [7:0]            csum_q, csum_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  wr_en_d;
   logic [PC_WIDTH-1:0]   wr_addr_d;
   logic [INST_WIDTH-1:0] wr_data_d;
   logic                  cpu_hold_d, busy_d, load_done_d, load_err_d;
   logic                  in_frame;
   logic                  go_err;
   logic [31:0]           image_bytes;

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      cnt_lo_d    = cnt_lo_q;
      nwords_d    = nwords_q;
      wcnt_d      = wcnt_q;
      lane_d      = lane_q;
      asm_d       = asm_q;
      csum_d      = csum_q;
      tmo_d       = '0;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr;
      wr_data_d   = wr_data;
      cpu_hold_d  = cpu_hold;
      busy_d      = busy;
      load_done_d = load_done;
      load_err_d  = load_err;
      go_err      = 1'b0;
      image_bytes = '0;

      // Address advances on the cycle after each write
      if (wr_en) begin
         wr_addr_d = wr_addr + PC_WIDTH'(4);
      end

      // Inter-byte idle timeout, only while a frame is open
      in_frame = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                 (state_q == S_DATA)   || (state_q == S_CSUM);
      if (in_frame && !rx_valid) begin
         tmo_d = tmo_q + TMO_W'(1);
         if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
            go_err = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_d     = S_CNT_LO;
               busy_d      = 1'b1;
               cpu_hold_d  = 1'b1;
               load_done_d = 1'b0;
               load_err_d  = 1'b0;
               csum_d      = 8'h00;
            end
         end
         S_CNT_LO: begin
            if (rx_valid) begin
               cnt_lo_d = rx_data;
               state_d  = S_CNT_HI;
            end
         end
         S_CNT_HI: begin
            if (rx_valid) begin
               nwords_d = {rx_data, cnt_lo_q};
               // 4N fits in 18 bits, zero-extended for the capacity compare
               image_bytes = {14'd0, nwords_d, 2'b00};
               if ((nwords_d == 16'd0) || (image_bytes > IMEM_BYTES)) begin
                  go_err = 1'b1;
               end else begin
                  state_d   = S_DATA;
                  wr_addr_d = BASE;
                  lane_d    = 2'd0;
                  wcnt_d    = 16'd0;
               end
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               csum_d = csum_q ^ rx_data;
               lane_d = lane_q + 2'd1;
               case (lane_q)
                  2'd0:    asm_d[7:0]   = rx_data;
                  2'd1:    asm_d[15:8]  = rx_data;
                  2'd2:    asm_d[23:16] = rx_data;
                  default: begin
                     // Lane 3 completes the word; it is written next cycle
                     wr_en_d   = 1'b1;
                     wr_data_d = INST_WIDTH'({rx_data, asm_q});
                     wcnt_d    = wcnt_q + 16'd1;
                     if (wcnt_d == nwords_q) begin
                        state_d = S_CSUM;
                     end
                  end
               endcase
            end
         end
         S_CSUM: begin
            if (rx_valid) begin
               if (rx_data == csum_q) begin
                  state_d     = S_IDLE;
                  load_done_d = 1'b1;
                  load_err_d  = 1'b0;
                  cpu_hold_d  = 1'b0;
                  busy_d      = 1'b0;
               end else begin
                  go_err = 1'b1;
               end
            end
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Failed frame: flag it and keep the core held; written words stay
      if (go_err) begin
         state_d     = S_ERR;
         load_err_d  = 1'b1;
         load_done_d = 1'b0;
         busy_d      = 1'b0;
         cpu_hold_d  = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_lo_q  <= '0;
         nwords_q  <= '0;
         wcnt_q    <= '0;
         lane_q    <= '0;
         asm_q     <= '0;
         csum_q    <= '0;
         tmo_q     <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= BASE;
         wr_data   <= '0;
         cpu_hold  <= 1'b1;
         busy      <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_lo_q  <= cnt_lo_d;
         nwords_q  <= nwords_d;
         wcnt_q    <= wcnt_d;
         lane_q    <= lane_d;
         asm_q     <= asm_d;
         csum_q    <= csum_d;
         tmo_q     <= tmo_d;
         wr_en     <= wr_en_d;
         wr_addr   <= wr_addr_d;
         wr_data   <= wr_data_d;
         cpu_hold  <= cpu_hold_d;
         busy      <= busy_d;
         load_done <= load_done_d;
         load_err  <= load_err_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. The stimulus side builds
// frames, derives the expected memory writes and frame outcome from the frame
// contents, and queues them; a monitor on the falling edge pops and compares.
module tb_imem_loader;

   localparam int unsigned TMO   = 16;
   localparam int unsigned IMEMB = 4096;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      int unsigned cyc;
   } exp_wr_t;

   typedef struct packed {
      logic        done;
      logic        err;
      logic        hold;
      int unsigned cyc;
   } exp_out_t;

   logic        clk;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        busy;
   logic        load_done;
   logic        load_err;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;
   int unsigned last_cyc = 0;
   logic        prev_done = 1'b0;
   logic        prev_err  = 1'b0;

   exp_wr_t    wq[$];
   exp_out_t   oq[$];
   logic [7:0] payload[$];

   imem_loader #(
      .PC_WIDTH      (32),
      .INST_WIDTH    (32),
      .IMEM_BYTES    (IMEMB),
      .BASE_ADDR     (0),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .load_done(load_done),
      .load_err (load_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every write and every frame outcome against the queues
   initial begin
      exp_wr_t  ew;
      exp_out_t eo;
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("flags_exclusive", 32'(load_done & load_err), 32'd0);
            if (wr_en) begin
               if (wq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_write addr=0x%0h data=0x%0h", wr_addr, wr_data);
               end else begin
                  ew = wq.pop_front();
                  chk("wr_addr", wr_addr, ew.addr);
                  chk("wr_data", wr_data, ew.data);
                  chk("wr_cycle", cyc, ew.cyc);
               end
            end
            if ((load_done && !prev_done) || (load_err && !prev_err)) begin
               if (oq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_outcome done=%0b err=%0b", load_done, load_err);
               end else begin
                  eo = oq.pop_front();
                  chk("out_done", 32'(load_done), 32'(eo.done));
                  chk("out_err", 32'(load_err), 32'(eo.err));
                  chk("out_hold", 32'(cpu_hold), 32'(eo.hold));
                  chk("out_busy", 32'(busy), 32'd0);
                  chk("out_cycle", cyc, eo.cyc);
               end
            end
         end
         prev_done = load_done;
         prev_err  = load_err;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = b;
      last_cyc = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
   endtask

   task automatic fill(input int nbytes);
      payload.delete();
      for (int j = 0; j < nbytes; j++) payload.push_back(8'($urandom));
   endtask

   // Sends a frame of n words from payload. stop_after>0 truncates the frame
   // after that many bytes; expect_tmo then queues the timeout error.
   task automatic send_frame(input int n, input bit bad, input int gmax,
                             input int stop_after, input bit expect_tmo);
      logic [7:0] fb[$];
      logic [7:0] x;
      logic [7:0] lo;
      logic [7:0] hi;
      bit         cnt_ok;
      int         d;
      exp_wr_t    w;
      exp_out_t   o;
      lo     = n[7:0];
      hi     = n[15:8];
      cnt_ok = (n != 0) && (4 * n <= int'(IMEMB));
      x      = 8'h00;
      fb.push_back(8'hA5);
      fb.push_back(lo);
      fb.push_back(hi);
      if (cnt_ok) begin
         for (int j = 0; j < 4 * n; j++) begin
            fb.push_back(payload[j]);
            x = x ^ payload[j];
         end
         fb.push_back(bad ? (x ^ 8'h01) : x);
      end
      for (int i = 0; i < fb.size(); i++) begin
         if (i > 0 && gmax > 0) idle($urandom_range(0, gmax));
         send_byte(fb[i]);
         if (i == 1) begin
            chk("sync_busy", 32'(busy), 32'd1);
            chk("sync_hold", 32'(cpu_hold), 32'd1);
            chk("sync_done_clr", 32'(load_done), 32'd0);
            chk("sync_err_clr", 32'(load_err), 32'd0);
         end
         d = i - 3;
         if (cnt_ok && d >= 0 && d < 4 * n && (d % 4) == 3) begin
            w.addr = 32'(4 * (d / 4));
            w.data = {payload[d], payload[d-1], payload[d-2], payload[d-3]};
            w.cyc  = last_cyc + 1;
            wq.push_back(w);
         end
         if (stop_after > 0 && i == stop_after - 1) begin
            if (expect_tmo) begin
               o.done = 1'b0;
               o.err  = 1'b1;
               o.hold = 1'b1;
               o.cyc  = last_cyc + 1 + TMO;
               oq.push_back(o);
            end
            break;
         end
         if (i == fb.size() - 1) begin
            o.done = cnt_ok && !bad;
            o.err  = !(cnt_ok && !bad);
            o.hold = !(cnt_ok && !bad);
            o.cyc  = last_cyc + 1;
            oq.push_back(o);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", wr_addr, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_load_done", 32'(load_done), 32'd0);
      chk("rst_load_err", 32'(load_err), 32'd0);
      reset = 1'b0;
      idle(3);

      // Normal two-word load with idle gaps
      payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      send_frame(2, 1'b0, 2, 0, 1'b0);
      idle(4);

      // Noise in IDLE is ignored and leaves the sticky flags alone
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      idle(2);
      chk("noise_done", 32'(load_done), 32'd1);
      chk("noise_hold", 32'(cpu_hold), 32'd0);
      chk("noise_busy", 32'(busy), 32'd0);

      // Same frame back-to-back, then with a bad checksum
      send_frame(2, 1'b0, 0, 0, 1'b0);
      idle(4);
      send_frame(2, 1'b1, 0, 0, 1'b0);
      idle(4);

      // Count bounds
      send_frame(0, 1'b0, 0, 0, 1'b0);
      idle(4);
      send_frame(16'h0401, 1'b0, 0, 0, 1'b0);
      idle(4);
      fill(4 * 16'h0400);
      send_frame(16'h0400, 1'b0, 0, 0, 1'b0);
      idle(4);

      // Timeout: A5 01 00 AA then silence
      payload = '{8'hAA, 8'h00, 8'h00, 8'h00};
      send_frame(1, 1'b0, 0, 4, 1'b1);
      idle(TMO + 8);

      // Randomized frames
      for (int k = 0; k < 6; k++) begin
         int n;
         n = $urandom_range(1, 8);
         fill(4 * n);
         send_frame(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 0, 1'b0);
         idle(4);
      end

      // Reset during word 3 of 8, then reload a one-word image
      fill(32);
      send_frame(8, 1'b0, 0, 13, 1'b0);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
      chk("mid_rst_wr_addr", wr_addr, 32'd0);
      chk("mid_rst_wr_data", wr_data, 32'd0);
      chk("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_load_done", 32'(load_done), 32'd0);
      chk("mid_rst_load_err", 32'(load_err), 32'd0);
      chk("mid_rst_writes_seen", 32'(wq.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);
      fill(4);
      send_frame(1, 1'b0, 1, 0, 1'b0);
      idle(30);

      chk("pending_writes", 32'(wq.size()), 32'd0);
      chk("pending_outcomes", 32'(oq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
